// File: rtl/sde_cdc_pkg.sv
// Shared definitions for the config CDC bus: word layout, channel limits and the
// scheduler state encoding. The destination-side decoder imports the same package.
package sde_cdc_pkg;

    localparam int BUS_W      = 32;
    localparam int PAYLOAD_W  = 28;
    localparam int TAG_W      = 3;
    localparam int TOGGLE_BIT = 31;
    localparam int TAG_LSB    = 28;
    localparam int MAX_CH     = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    function automatic logic [BUS_W-1:0] pack_word(
        input logic                 toggle,
        input logic [TAG_W-1:0]     tag,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {toggle, tag, payload};
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin pick over up to 8 requesters, searching upward from
// last+1 and wrapping. Unused (zero) request bits never win.
module rr_arbiter_8
    import sde_cdc_pkg::*;
(
    input  logic [MAX_CH-1:0] req,
    input  logic [TAG_W-1:0]  last,
    output logic              valid,
    output logic [TAG_W-1:0]  ch
);

    always_comb begin
        logic [TAG_W-1:0] idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        valid = 1'b0;
        ch    = '0;
        idx   = '0;
        // The 3-bit index wraps naturally; i == MAX_CH lands back on last itself.
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = last + TAG_W'(i);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                ch    = idx;
            end
        end
    end

endmodule

// File: rtl/sde_cfg_cdc_sched.sv
// Source-side scheduler sharing one 32-bit CDC bus among NCH config requesters:
// round-robin grant, tagged+toggled word, held HOLD cycles, then a one-cycle ACK.
module sde_cfg_cdc_sched #(
    parameter int NCH  = 4,
    parameter int HOLD = 8
) (
    input  logic                                   CLK,
    input  logic                                   RSTN,
    input  logic [NCH-1:0]                         REQ,
    input  logic [NCH*sde_cdc_pkg::PAYLOAD_W-1:0]  DATA,
    output logic [NCH-1:0]                         ACK,
    output logic [sde_cdc_pkg::BUS_W-1:0]          BUS_OUT,
    output logic                                   BUSY
);

    localparam int CNT_W     = $clog2(HOLD);
    localparam int TAG_W     = sde_cdc_pkg::TAG_W;
    localparam int PAYLOAD_W = sde_cdc_pkg::PAYLOAD_W;
    localparam int MAX_CH    = sde_cdc_pkg::MAX_CH;

    sde_cdc_pkg::state_t state, state_nx;
    logic [TAG_W-1:0]          last, last_nx;
    logic [CNT_W-1:0]          cnt, cnt_nx;
    logic [NCH-1:0]            ack_nx;
    logic [sde_cdc_pkg::BUS_W-1:0] bus_nx;
    logic                      busy_nx;

    logic [MAX_CH-1:0]         eligible;
    logic                      arb_valid;
    logic [TAG_W-1:0]          arb_ch;
    logic [PAYLOAD_W-1:0]      grant_payload;
    logic                      toggle;
    logic [TAG_W-1:0]          cur_tag;

    // Masking with the registered ACK keeps a channel that just completed out of
    // the next pick, so a requester dropping REQ on ACK is never served twice.
    assign eligible = MAX_CH'(REQ & ~ACK);
    assign toggle   = BUS_OUT[sde_cdc_pkg::TOGGLE_BIT];
    assign cur_tag  = BUS_OUT[sde_cdc_pkg::TAG_LSB +: TAG_W];

    rr_arbiter_8 u_arb (
        .req   (eligible),
        .last  (last),
        .valid (arb_valid),
        .ch    (arb_ch)
    );

    always_comb begin
        grant_payload = '0;
        for (int k = 0; k < NCH; k++) begin
            if (arb_ch == TAG_W'(k)) grant_payload = DATA[k*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        ack_nx   = '0;
        bus_nx   = BUS_OUT;
        busy_nx  = BUSY;
        unique case (state)
            sde_cdc_pkg::IDLE: begin
                if (arb_valid) begin
                    bus_nx   = sde_cdc_pkg::pack_word(~toggle, arb_ch, grant_payload);
                    last_nx  = arb_ch;
                    cnt_nx   = CNT_W'(HOLD - 1);
                    busy_nx  = 1'b1;
                    state_nx = sde_cdc_pkg::HOLD;
                end
            end
            sde_cdc_pkg::HOLD: begin
                if (cnt == '0) begin
                    for (int k = 0; k < NCH; k++) ack_nx[k] = (cur_tag == TAG_W'(k));
                    busy_nx  = 1'b0;
                    state_nx = sde_cdc_pkg::IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = sde_cdc_pkg::IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= sde_cdc_pkg::IDLE;
            last    <= TAG_W'(NCH - 1);
            cnt     <= '0;
            ACK     <= '0;
            BUS_OUT <= '0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
            ACK     <= ack_nx;
            BUS_OUT <= bus_nx;
            BUSY    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_sde_cfg_cdc_sched.sv
// Directed self-checking bench for sde_cfg_cdc_sched: a 4-channel instance for the
// main scenarios and an 8-channel instance for the top-tag case.
module tb_sde_cfg_cdc_sched;

    logic          CLK;
    logic          RSTN;
    logic [3:0]    req;
    logic [4*28-1:0] data;
    logic [3:0]    ack;
    logic [31:0]   bus_out;
    logic          busy;

    logic [7:0]    req8;
    logic [8*28-1:0] data8;
    logic [7:0]    ack8;
    logic [31:0]   bus8;
    logic          busy8;

    int checks = 0;
    int errors = 0;

    sde_cfg_cdc_sched #(.NCH(4), .HOLD(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(req), .DATA(data),
        .ACK(ack), .BUS_OUT(bus_out), .BUSY(busy)
    );

    sde_cfg_cdc_sched #(.NCH(8), .HOLD(8)) dut8 (
        .CLK(CLK), .RSTN(RSTN), .REQ(req8), .DATA(data8),
        .ACK(ack8), .BUS_OUT(bus8), .BUSY(busy8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int ch_seq [5];
        logic [31:0] exp_word;
        ch_seq = '{0, 1, 2, 3, 0};

        RSTN  = 1'b0;
        req   = '0;
        data  = '0;
        req8  = '0;
        data8 = '0;
        repeat (2) step();
        check("rst_bus", bus_out, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_bus8", bus8, 32'h0);
        check("rst_ack8", 32'(ack8), 32'h0);
        RSTN = 1'b1;

        // Single channel 0: launch, 8-cycle hold, ACK in cycle 9.
        data[27:0] = 28'h0ABCDEF;
        req = 4'b0001;
        step();
        check("t1_launch", bus_out, 32'h80ABCDEF);
        for (int c = 1; c <= 8; c++) begin
            check("t1_hold_bus", bus_out, 32'h80ABCDEF);
            check("t1_hold_busy", 32'(busy), 32'h1);
            check("t1_hold_ack", 32'(ack), 32'h0);
            step();
        end
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_ack_busy", 32'(busy), 32'h0);
        // Cycle 9 masks channel 0 (ACK high), so the relaunch is granted in cycle 10
        // and visible in cycle 11: nine cycles lie between the two launches.
        step();
        check("t1_gap_bus", bus_out, 32'h80ABCDEF);
        check("t1_gap_busy", 32'(busy), 32'h0);
        check("t1_gap_ack", 32'(ack), 32'h0);
        step();
        check("t1_relaunch", bus_out, 32'h00ABCDEF);
        check("t1_relaunch_busy", 32'(busy), 32'h1);
        repeat (8) step();
        check("t1_ack2", 32'(ack), 32'h1);
        req = 4'b0000;
        step();
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Round robin from reset with all four channels requesting.
        RSTN = 1'b0;
        step();
        RSTN = 1'b1;
        for (int k = 0; k < 4; k++) data[k*28 +: 28] = 28'h1234560 + 28'(k);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            exp_word = {(g % 2 == 0) ? 1'b1 : 1'b0, 3'(ch_seq[g]), 28'h1234560 + 28'(ch_seq[g])};
            check("rr_launch", bus_out, exp_word);
            check("rr_busy", 32'(busy), 32'h1);
            repeat (7) step();
            check("rr_hold_end", bus_out, exp_word);
            step();
            check("rr_ack", 32'(ack), 32'(4'b0001 << ch_seq[g]));
            check("rr_ack_busy", 32'(busy), 32'h0);
            if (g == 4) req = 4'b0000;
        end

        // Channel 2 withdraws during HOLD: transfer completes, no regrant.
        data[2*28 +: 28] = 28'h2222222;
        req = 4'b0100;
        step();
        check("wd_launch", bus_out, 32'h22222222);
        repeat (3) step();
        req = 4'b0000;
        repeat (4) step();
        check("wd_hold_end", bus_out, 32'h22222222);
        step();
        check("wd_ack", 32'(ack), 32'h4);
        step();
        check("wd_ack_clear", 32'(ack), 32'h0);
        repeat (3) step();
        check("wd_no_regrant", 32'(busy), 32'h0);
        check("wd_bus_stable", bus_out, 32'h22222222);

        // Reset in hold cycle 4 of channel 1.
        data[1*28 +: 28] = 28'h1111111;
        req = 4'b0010;
        step();
        check("mr_launch", bus_out, 32'h91111111);
        repeat (3) step();
        RSTN = 1'b0;
        #1;
        check("mr_bus", bus_out, 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_ack", 32'(ack), 32'h0);
        data[27:0] = 28'h0000005;
        req = 4'b0011;
        step();
        check("mr_ack_in_rst", 32'(ack), 32'h0);
        RSTN = 1'b1;
        step();
        check("mr_first_ch0", bus_out, 32'h80000005);
        repeat (7) step();
        check("mr_no_ack1", 32'(ack), 32'h0);
        step();
        check("mr_ack0", 32'(ack), 32'h1);
        step();
        check("mr_then_ch1", bus_out, 32'h11111111);
        req = 4'b0000;
        repeat (8) step();
        check("mr_ack1", 32'(ack), 32'h2);
        step();

        // Eight-channel instance, channel 7 only.
        data8[7*28 +: 28] = 28'h7654321;
        req8 = 8'h80;
        step();
        check("c7_launch", bus8, 32'hF7654321);
        check("c7_ack_quiet", 32'(ack8), 32'h0);
        repeat (7) step();
        check("c7_hold_end", bus8, 32'hF7654321);
        check("c7_hold_ack", 32'(ack8), 32'h0);
        step();
        check("c7_ack", 32'(ack8), 32'h80);
        req8 = 8'h00;
        step();
        check("c7_ack_clear", 32'(ack8), 32'h0);
        check("c7_idle", 32'(busy8), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
